// File: rtl/mm_tile_loader_if.sv
// Bundle of every non-clock signal of the tile loader: the host command
// channel, the two word streams, the multiplier RAM/control side and the
// status pulses. The loader takes the slave view; the host/multiplier
// environment takes the master view.
//
// Handshake rule for cmd, a and b: a transfer happens on a rising clk edge
// exactly when valid and ready are both high in the cycle before that edge.
// Ready is a function of the loader's registered state only; it never looks
// at valid. Valid is not required to stay high until accepted, but data
// must be stable in any cycle where valid is high.
interface mm_tile_loader_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 7
);
  // Host command channel
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_len_a;
  logic [ADDR_W-1:0] cmd_len_b;

  // Input-matrix stream (RAM port A)
  logic              a_valid;
  logic              a_ready;
  logic [WIDTH-1:0]  a_data;

  // Weight stream (RAM port B)
  logic              b_valid;
  logic              b_ready;
  logic [WIDTH-1:0]  b_data;

  // Multiplier side
  logic              mm_w_a;
  logic              mm_w_b;
  logic [WIDTH-1:0]  mm_data_a;
  logic [WIDTH-1:0]  mm_data_b;
  logic [ADDR_W-1:0] mm_addr_a;
  logic [ADDR_W-1:0] mm_addr_b;
  logic              mm_start;
  logic              mm_done;

  // Status to the host sequencer
  logic              busy;
  logic              tile_done;
  logic              cmd_err;
  logic              tile_err;

  // Current FSM state, for observation only
  logic [2:0]        state_dbg;

  modport master (
    output cmd_valid, cmd_len_a, cmd_len_b,
    output a_valid, a_data, b_valid, b_data,
    output mm_done,
    input  cmd_ready, a_ready, b_ready,
    input  mm_w_a, mm_w_b, mm_data_a, mm_data_b, mm_addr_a, mm_addr_b, mm_start,
    input  busy, tile_done, cmd_err, tile_err, state_dbg
  );

  modport slave (
    input  cmd_valid, cmd_len_a, cmd_len_b,
    input  a_valid, a_data, b_valid, b_data,
    input  mm_done,
    output cmd_ready, a_ready, b_ready,
    output mm_w_a, mm_w_b, mm_data_a, mm_data_b, mm_addr_a, mm_addr_b, mm_start,
    output busy, tile_done, cmd_err, tile_err, state_dbg
  );
endinterface

// File: rtl/mm_tile_loader.sv
// Tile loader feeding the matrix multiplier. Takes a command with two
// stream lengths, writes the A stream to RAM port A and the B stream to RAM
// port B at consecutive addresses from 0, then pulses the multiplier start
// and waits for a rising edge of its Done, reporting success, a rejected
// command, or a Done timeout with one-cycle pulses.
module mm_tile_loader #(
  parameter int WIDTH   = 32,
  parameter int HEIGHT  = 48,
  parameter int ADDR_W  = $clog2(HEIGHT) + 1,
  parameter int TIMEOUT = 4096
) (
  input  logic            clk,
  input  logic            rst,
  mm_tile_loader_if.slave bus
);

  localparam int                TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] MAX_LEN  = ADDR_W'(HEIGHT);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_FLUSH = 3'd2,
    S_START = 3'd3,
    S_WAIT  = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] len_a_q;
  logic [ADDR_W-1:0] len_b_q;
  logic [ADDR_W-1:0] cnt_a_q;
  logic [ADDR_W-1:0] cnt_b_q;
  logic              w_a_q;
  logic              w_b_q;
  logic [WIDTH-1:0]  data_a_q;
  logic [WIDTH-1:0]  data_b_q;
  logic [ADDR_W-1:0] addr_a_q;
  logic [ADDR_W-1:0] addr_b_q;
  logic              start_q;
  logic              tile_done_q;
  logic              cmd_err_q;
  logic              tile_err_q;
  logic              done_prev_q;
  logic [TMR_W-1:0]  timer_q;

  logic              a_rdy;
  logic              b_rdy;
  logic              hs_a;
  logic              hs_b;
  logic [ADDR_W-1:0] cnt_a_d;
  logic [ADDR_W-1:0] cnt_b_d;
  logic              cmd_fire;
  logic              cmd_bad;
  logic              done_rise;
  logic              load_last;

  // Handshake decode, counter next values and command legality check.
  always_comb begin
    a_rdy     = (state_q == S_LOAD) && (cnt_a_q < len_a_q);
    b_rdy     = (state_q == S_LOAD) && (cnt_b_q < len_b_q);
    hs_a      = a_rdy && bus.a_valid;
    hs_b      = b_rdy && bus.b_valid;
    cnt_a_d   = hs_a ? (cnt_a_q + ADDR_W'(1)) : cnt_a_q;
    cnt_b_d   = hs_b ? (cnt_b_q + ADDR_W'(1)) : cnt_b_q;
    load_last = (cnt_a_d == len_a_q) && (cnt_b_d == len_b_q);
    cmd_fire  = (state_q == S_IDLE) && bus.cmd_valid;
    cmd_bad   = (bus.cmd_len_a == '0) || (bus.cmd_len_b == '0) ||
                (bus.cmd_len_a > MAX_LEN) || (bus.cmd_len_b > MAX_LEN);
    // Only a fresh 0->1 transition counts, so a Done left high by the
    // previous tile cannot complete this one.
    done_rise = bus.mm_done && !done_prev_q;
  end

  // Control FSM plus the registered RAM write path and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      len_a_q     <= '0;
      len_b_q     <= '0;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      w_a_q       <= 1'b0;
      w_b_q       <= 1'b0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      start_q     <= 1'b0;
      tile_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      tile_err_q  <= 1'b0;
      done_prev_q <= 1'b0;
      timer_q     <= '0;
    end else begin
      // Pulses default low; each is raised for a single cycle below.
      start_q     <= 1'b0;
      tile_done_q <= 1'b0;
      cmd_err_q   <= 1'b0;
      tile_err_q  <= 1'b0;
      done_prev_q <= bus.mm_done;

      // A beat accepted this cycle becomes a RAM write next cycle at the
      // pre-increment address. Ready is only ever high in LOAD, so no write
      // strobe can appear from START onwards.
      w_a_q <= hs_a;
      w_b_q <= hs_b;
      if (hs_a) begin
        data_a_q <= bus.a_data;
        addr_a_q <= cnt_a_q;
      end
      if (hs_b) begin
        data_b_q <= bus.b_data;
        addr_b_q <= cnt_b_q;
      end
      cnt_a_q <= cnt_a_d;
      cnt_b_q <= cnt_b_d;

      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            if (cmd_bad) begin
              cmd_err_q <= 1'b1;
            end else begin
              len_a_q <= bus.cmd_len_a;
              len_b_q <= bus.cmd_len_b;
              cnt_a_q <= '0;
              cnt_b_q <= '0;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          // Leave on the edge of the final handshake of the slower stream.
          if (load_last) begin
            state_q <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // The last write strobe is visible during this cycle.
          start_q <= 1'b1;
          state_q <= S_START;
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A rising Done in the same cycle as the timeout still succeeds.
          if (done_rise) begin
            tile_done_q <= 1'b1;
            state_q     <= S_DONE;
          end else if (timer_q == TMR_LAST) begin
            tile_err_q <= 1'b1;
            state_q    <= S_IDLE;
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.mm_w_a    = w_a_q;
  assign bus.mm_w_b    = w_b_q;
  assign bus.mm_data_a = data_a_q;
  assign bus.mm_data_b = data_b_q;
  assign bus.mm_addr_a = addr_a_q;
  assign bus.mm_addr_b = addr_b_q;
  assign bus.mm_start  = start_q;
  assign bus.tile_done = tile_done_q;
  assign bus.cmd_err   = cmd_err_q;
  assign bus.tile_err  = tile_err_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_mm_tile_loader.sv
// Directed bench for mm_tile_loader. Drivers push expected RAM writes and
// expected status events into queues as beats/commands are issued; a
// negedge monitor pops and compares whenever the loader shows a write
// strobe or a pulse. Cycle-exact latencies are checked in the stimulus.
module tb_mm_tile_loader;
  localparam int W  = 32;
  localparam int H  = 48;
  localparam int AW = $clog2(H) + 1;
  localparam int TO = 32;

  localparam logic [3:0] EV_START = 4'b0001;
  localparam logic [3:0] EV_DONE  = 4'b0010;
  localparam logic [3:0] EV_CERR  = 4'b0100;
  localparam logic [3:0] EV_TERR  = 4'b1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   chk = 0;
  int   errs = 0;

  int n_start = 0, n_done = 0, n_cerr = 0, n_terr = 0;
  int start_cyc = 0, done_cyc = 0, cerr_cyc = 0, terr_cyc = 0;
  int last_hs_a = 0, last_hs_b = 0;

  logic [AW+W-1:0] exp_a_q[$];
  logic [AW+W-1:0] exp_b_q[$];
  logic [3:0]      exp_ev_q[$];

  mm_tile_loader_if #(.WIDTH(W), .ADDR_W(AW)) bus();

  mm_tile_loader #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    chk++;
    errs++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    logic [3:0] ev;
    if (bus.mm_w_a) begin
      if (exp_a_q.size() == 0) fail_now("wr_a unexpected write");
      else check("wr_a", {bus.mm_addr_a, bus.mm_data_a}, exp_a_q.pop_front());
    end
    if (bus.mm_w_b) begin
      if (exp_b_q.size() == 0) fail_now("wr_b unexpected write");
      else check("wr_b", {bus.mm_addr_b, bus.mm_data_b}, exp_b_q.pop_front());
    end
    ev = {bus.tile_err, bus.cmd_err, bus.tile_done, bus.mm_start};
    if (ev != 4'b0000) begin
      if (exp_ev_q.size() == 0) begin
        chk++;
        errs++;
        $display("FAIL event unexpected: got %b, none expected (cycle %0d)", ev, cyc);
      end else begin
        check("event", ev, exp_ev_q.pop_front());
      end
      if (bus.mm_start)  begin n_start++; start_cyc = cyc; end
      if (bus.tile_done) begin n_done++;  done_cyc  = cyc; end
      if (bus.cmd_err)   begin n_cerr++;  cerr_cyc  = cyc; end
      if (bus.tile_err)  begin n_terr++;  terr_cyc  = cyc; end
    end
  end

  function automatic int get_cnt(input int which);
    case (which)
      0:       return n_start;
      1:       return n_done;
      2:       return n_cerr;
      default: return n_terr;
    endcase
  endfunction

  function automatic int get_stamp(input int which);
    case (which)
      0:       return start_cyc;
      1:       return done_cyc;
      2:       return cerr_cyc;
      default: return terr_cyc;
    endcase
  endfunction

  // Wait (bounded) for the monitor to see event 'which'; returns its cycle.
  task automatic wait_evt(input string name, input int which, input int budget, output int stamp);
    int base;
    int k;
    base = get_cnt(which);
    k = 0;
    while (get_cnt(which) == base && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    if (get_cnt(which) == base) begin
      fail_now({name, " timed out"});
      stamp = -1;
    end else begin
      stamp = get_stamp(which);
    end
  endtask

  // Driver: present a command until accepted; returns the accept cycle.
  task automatic send_cmd(input int la, input int lb, output int acc);
    int k;
    k = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_len_a = AW'(la);
    bus.cmd_len_b = AW'(lb);
    @(negedge clk);
    while (!bus.cmd_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    check("cmd_ready at issue", bus.cmd_ready, 1);
    acc = cyc;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  // Driver: port-A stream; gap=1 offers valid only every other cycle.
  task automatic drive_a(input int n, input int base, input bit gap);
    int sent;
    int k;
    sent = 0;
    k = 0;
    while (sent < n && k < 400) begin
      @(posedge clk); #1;
      bus.a_valid = gap ? ((k % 2) == 0) : 1'b1;
      bus.a_data  = W'(base + sent);
      @(negedge clk);
      if (bus.a_valid && bus.a_ready) begin
        exp_a_q.push_back({AW'(sent), W'(base + sent)});
        last_hs_a = cyc;
        sent++;
      end
      k++;
    end
    if (sent < n) fail_now("drive_a beats not accepted");
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
  endtask

  // Driver: port-B stream.
  task automatic drive_b(input int n, input int base, input bit gap);
    int sent;
    int k;
    sent = 0;
    k = 0;
    while (sent < n && k < 400) begin
      @(posedge clk); #1;
      bus.b_valid = gap ? ((k % 2) == 0) : 1'b1;
      bus.b_data  = W'(base + sent);
      @(negedge clk);
      if (bus.b_valid && bus.b_ready) begin
        exp_b_q.push_back({AW'(sent), W'(base + sent)});
        last_hs_b = cyc;
        sent++;
      end
      k++;
    end
    if (sent < n) fail_now("drive_b beats not accepted");
    @(posedge clk); #1;
    bus.b_valid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, " ctl"},
          {bus.cmd_ready, bus.a_ready, bus.b_ready, bus.mm_w_a, bus.mm_w_b,
           bus.mm_start, bus.busy, bus.tile_done, bus.cmd_err, bus.tile_err},
          10'b10_0000_0000);
    check({name, " port a"}, {bus.mm_addr_a, bus.mm_data_a}, 0);
    check({name, " port b"}, {bus.mm_addr_b, bus.mm_data_b}, 0);
    check({name, " state"}, bus.state_dbg, 0);
  endtask

  // Raise Done some cycles after start and confirm tile_done one cycle later.
  task automatic finish_tile(input string name, input int delay);
    int r;
    int d;
    repeat (delay) @(posedge clk);
    #1;
    exp_ev_q.push_back(EV_DONE);
    bus.mm_done = 1'b1;
    r = cyc;
    wait_evt({name, " tile_done"}, 1, 20, d);
    check({name, " done latency"}, d, r + 1);
  endtask

  // Main stimulus
  initial begin
    int acc, s, e, t, base_done, base_start;
    bus.cmd_valid = 1'b0; bus.cmd_len_a = '0; bus.cmd_len_b = '0;
    bus.a_valid = 1'b0; bus.a_data = '0;
    bus.b_valid = 1'b0; bus.b_data = '0;
    bus.mm_done = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal 16/16 tile, both streams always valid
    exp_ev_q.push_back(EV_START);
    send_cmd(16, 16, acc);
    fork
      drive_a(16, 100, 1'b0);
      drive_b(16, 200, 1'b0);
    join
    wait_evt("nominal start", 0, 20, s);
    check("nominal start latency", s, ((last_hs_a > last_hs_b) ? last_hs_a : last_hs_b) + 2);
    finish_tile("nominal", 20);
    @(negedge clk);
    check("nominal busy after done", bus.busy, 0);
    check("nominal cmd_ready after done", bus.cmd_ready, 1);

    // Command rejects: zero length A, then B above HEIGHT
    exp_ev_q.push_back(EV_CERR);
    send_cmd(0, 5, acc);
    wait_evt("reject len_a=0", 2, 10, e);
    check("reject len_a=0 latency", e, acc + 1);
    check("reject len_a=0 idle", {bus.busy, bus.a_ready, bus.b_ready, bus.cmd_ready}, 4'b0001);
    exp_ev_q.push_back(EV_CERR);
    send_cmd(5, 49, acc);
    wait_evt("reject len_b=49", 2, 10, e);
    check("reject len_b=49 latency", e, acc + 1);
    check("reject len_b=49 idle", {bus.busy, bus.a_ready, bus.b_ready, bus.cmd_ready}, 4'b0001);

    // Asymmetric: A=4 with gaps, B=8 held off until A is complete
    bus.mm_done = 1'b0;
    base_start = n_start;
    exp_ev_q.push_back(EV_START);
    send_cmd(4, 8, acc);
    drive_a(4, 300, 1'b1);
    @(negedge clk);
    check("asym a_ready low after 4 beats", bus.a_ready, 0);
    check("asym b_ready still high", bus.b_ready, 1);
    check("asym no start before B", n_start, base_start);
    drive_b(8, 400, 1'b0);
    wait_evt("asym start", 0, 20, s);
    check("asym start after 8th B", s, last_hs_b + 2);
    finish_tile("asym", 3);

    // Sticky Done: high entering WAIT, low 3 cycles, then high again
    base_done = n_done;
    exp_ev_q.push_back(EV_START);
    send_cmd(2, 2, acc);
    fork
      drive_a(2, 800, 1'b0);
      drive_b(2, 900, 1'b0);
    join
    wait_evt("sticky start", 0, 20, s);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.mm_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("sticky no early done", n_done, base_done);
    check("sticky still waiting", bus.busy, 1);
    finish_tile("sticky", 1);
    bus.mm_done = 1'b0;

    // Timeout with Done held low
    base_done = n_done;
    exp_ev_q.push_back(EV_START);
    send_cmd(1, 1, acc);
    fork
      drive_a(1, 1000, 1'b0);
      drive_b(1, 1100, 1'b0);
    join
    wait_evt("timeout start", 0, 20, s);
    exp_ev_q.push_back(EV_TERR);
    wait_evt("timeout tile_err", 3, TO + 10, t);
    check("timeout latency", t, s + TO + 1);
    check("timeout cmd_ready", bus.cmd_ready, 1);
    check("timeout no tile_done", n_done, base_done);

    // Reset in the middle of loading A
    send_cmd(16, 16, acc);
    drive_a(5, 500, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset mid-load");
    exp_ev_q.push_back(EV_START);
    send_cmd(2, 2, acc);
    fork
      drive_a(2, 600, 1'b0);
      drive_b(2, 700, 1'b0);
    join
    wait_evt("post-reset start", 0, 20, s);
    finish_tile("post-reset", 4);
    bus.mm_done = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("exp_a drained", exp_a_q.size(), 0);
    check("exp_b drained", exp_b_q.size(), 0);
    check("exp_ev drained", exp_ev_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", chk, errs);
    $finish;
  end

endmodule
